// File: rtl/add_operand_sequencer.sv
// add_operand_sequencer
// ---------------------
// Collects two operands from a shared din bus, one per load rising edge. It
// presents them to an external N-bit ripple adder on a/b, captures the
// adder's sum and carry-out one cycle later, and holds the result with done=1
// until the next entry.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous, active-high reset
//   load      - operand-entry strobe (level); only its rising edge acts
//   din       - operand value, sampled on a load rising edge
//   a, b      - registered operands driven to the external adder
//   sum_in    - adder sum (combinational from a and b)
//   cout_in   - adder carry-out
//   result    - registered sum
//   carry     - registered carry-out
//   zero      - 1 when the captured result and carry are both 0
//   done      - result/carry/zero valid (HOLD state only)
//   state     - current FSM state encoding, for debug/LEDs
//   op_count  - completed additions, wraps 255 -> 0
module add_operand_sequencer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] din,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    input  logic [N-1:0] sum_in,
    input  logic         cout_in,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         done,
    output logic [1:0]   state,
    output logic [7:0]   op_count
);

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        EXEC   = 2'b10,
        HOLD   = 2'b11
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          load_prev_reg;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  result_reg;
    logic          carry_reg;
    logic          zero_reg;
    logic [7:0]    op_count_reg;

    logic          load_edge;
    logic          capture_a;
    logic          capture_b;
    logic          exec_cycle;

    // The history register resets to 1 so that a load still held high when
    // reset is released is not mistaken for a fresh edge.
    assign load_edge  = load & ~load_prev_reg;

    // HOLD accepts a new A directly so operations can be chained without
    // passing through WAIT_A.
    assign capture_a  = load_edge & ((state_reg == WAIT_A) || (state_reg == HOLD));
    assign capture_b  = load_edge & (state_reg == WAIT_B);
    assign exec_cycle = (state_reg == EXEC);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= WAIT_A;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. EXEC always lasts exactly one cycle, so any load
    // activity in that cycle has no effect.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            WAIT_A: if (load_edge) state_next = WAIT_B;
            WAIT_B: if (load_edge) state_next = EXEC;
            EXEC:   state_next = HOLD;
            HOLD:   if (load_edge) state_next = WAIT_B;
            default: state_next = WAIT_A;
        endcase
    end

    // Datapath. The operands change only on their own capture edges, so
    // a and b are stable through EXEC and sum_in has a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_prev_reg <= 1'b1;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b1;
            op_count_reg  <= 8'd0;
        end else begin
            load_prev_reg <= load;
            if (capture_a) begin
                a_reg <= din;
            end
            if (capture_b) begin
                b_reg <= din;
            end
            // The result registers update only here, so they keep the
            // previous operation's values while the next operands are entered.
            if (exec_cycle) begin
                result_reg   <= sum_in;
                carry_reg    <= cout_in;
                zero_reg     <= (sum_in == '0) && !cout_in;
                op_count_reg <= op_count_reg + 8'd1;
            end
        end
    end

    assign a        = a_reg;
    assign b        = b_reg;
    assign result   = result_reg;
    assign carry    = carry_reg;
    assign zero     = zero_reg;
    assign done     = (state_reg == HOLD);
    assign state    = state_reg;
    assign op_count = op_count_reg;

endmodule

// File: tb/tb_add_operand_sequencer.sv
// Testbench for add_operand_sequencer (N=4). A behavioural adder closes the
// a/b -> sum_in/cout_in loop. Expected results are pushed to a scoreboard
// queue when operand B is driven. They are popped and compared when done
// rises.
module tb_add_operand_sequencer;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         load;
    logic [N-1:0] din;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum_in;
    logic         cout_in;
    logic [N-1:0] result;
    logic         carry;
    logic         zero;
    logic         done;
    logic [1:0]   state;
    logic [7:0]   op_count;

    add_operand_sequencer #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .din      (din),
        .a        (a),
        .b        (b),
        .sum_in   (sum_in),
        .cout_in  (cout_in),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .done     (done),
        .state    (state),
        .op_count (op_count)
    );

    // Downstream ripple adder model
    assign {cout_in, sum_in} = {1'b0, a} + {1'b0, b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] res;
        logic         cy;
        logic         z;
        logic [7:0]   cnt;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           txn    = 0;
    logic [N-1:0] model_a  = '0;
    logic [7:0]   exp_count = 8'd0;
    logic [N-1:0] last_res = '0;
    logic         last_cy  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operand A entry: from WAIT_A or chained from HOLD
    task automatic enter_a(input logic [N-1:0] v);
        din  = v;
        load = 1'b1;
        tick();
        check("done_drop_on_a", 32'(done), 32'd0);
        load = 1'b0;
        tick();
        model_a = v;
        check("state_wait_b", 32'(state), 32'd1);
        check("a_captured", 32'(a), 32'(v));
        check("result_kept", 32'(result), 32'(last_res));
        check("carry_kept", 32'(carry), 32'(last_cy));
    endtask

    // Operand B entry: push expectation, then wait for done and compare
    task automatic enter_b(input logic [N-1:0] v);
        logic [N:0] s;
        exp_t       e;
        exp_t       got;
        int         n;
        s = {1'b0, model_a} + {1'b0, v};
        exp_count = exp_count + 8'd1;
        e.res = s[N-1:0];
        e.cy  = s[N];
        e.z   = (s == '0);
        e.cnt = exp_count;
        din  = v;
        load = 1'b1;
        sb.push_back(e);
        tick();
        check("state_exec", 32'(state), 32'd2);
        check("done_low_exec", 32'(done), 32'd0);
        check("a_stable_exec", 32'(a), 32'(model_a));
        check("b_captured", 32'(b), 32'(v));
        load = 1'b0;
        tick();
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        check("done_latency_extra", 32'(n), 32'd0);
        check("done_high", 32'(done), 32'd1);
        check("sb_nonempty", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            check("result", 32'(result), 32'(got.res));
            check("carry", 32'(carry), 32'(got.cy));
            check("zero", 32'(zero), 32'(got.z));
            check("op_count", 32'(op_count), 32'(got.cnt));
            last_res = got.res;
            last_cy  = got.cy;
        end
        txn++;
        $display("txn %0d: a=%0d b=%0d result=%0d carry=%0d zero=%0d op_count=%0d",
                 txn, model_a, v, result, carry, zero, op_count);
    endtask

    task automatic check_reset_values(input string when);
        check({"rst_state_", when}, 32'(state), 32'd0);
        check({"rst_a_", when}, 32'(a), 32'd0);
        check({"rst_b_", when}, 32'(b), 32'd0);
        check({"rst_result_", when}, 32'(result), 32'd0);
        check({"rst_carry_", when}, 32'(carry), 32'd0);
        check({"rst_zero_", when}, 32'(zero), 32'd1);
        check({"rst_done_", when}, 32'(done), 32'd0);
        check({"rst_op_count_", when}, 32'(op_count), 32'd0);
    endtask

    initial begin
        // Reset, with load held high across the release
        rst  = 1'b1;
        load = 1'b1;
        din  = '0;
        tick();
        tick();
        check_reset_values("init");
        rst = 1'b0;
        tick();
        tick();
        check("held_load_no_edge", 32'(state), 32'd0);
        load = 1'b0;
        tick();

        // 3 + 5
        enter_a(4'd3);
        enter_b(4'd5);
        // 9 + 7 overflows to carry
        enter_a(4'd9);
        enter_b(4'd7);
        // 0 + 0
        enter_a(4'd0);
        enter_b(4'd0);
        // Chained from HOLD: 15 + 1
        enter_a(4'd15);
        enter_b(4'd1);

        // Asynchronous reset in the middle of EXEC
        enter_a(4'd1);
        din  = 4'd2;
        load = 1'b1;
        tick();
        check("state_exec_pre_rst", 32'(state), 32'd2);
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async");
        tick();
        tick();
        rst = 1'b0;
        exp_count = 8'd0;
        last_res  = '0;
        last_cy   = 1'b0;
        tick();

        // Load held high for 10 cycles in WAIT_A: only A captured
        din  = 4'd2;
        load = 1'b1;
        repeat (10) tick();
        check("held_state", 32'(state), 32'd1);
        check("held_a", 32'(a), 32'd2);
        check("held_b", 32'(b), 32'd0);
        load = 1'b0;
        tick();
        check("held_state_after", 32'(state), 32'd1);
        model_a = 4'd2;
        enter_b(4'd4);

        // Wrap op_count: 1 done so far, 255 more reach 0
        for (int i = 0; i < 255; i++) begin
            enter_a(4'($urandom_range(0, 15)));
            enter_b(4'($urandom_range(0, 15)));
        end
        check("op_count_wrap", 32'(op_count), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_operand_sequencer.md
ADD_OPERAND_SEQUENCER -- requirements
Module: add_operand_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 4: operand and result width in bits; legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port load, input, 1 bit: operand-entry strobe, level, synchronous to clk.
REQ-005 The block SHALL have port din, input, N bits: operand value sampled on a load rising edge.
REQ-006 The block SHALL have port a, output, N bits: operand A, driven to the downstream N-bit ripple adder.
REQ-007 The block SHALL have port b, output, N bits: operand B, driven to the downstream N-bit ripple adder.
REQ-008 The block SHALL have port sum_in, input, N bits: adder sum, combinational from a and b.
REQ-009 The block SHALL have port cout_in, input, 1 bit: adder carry-out.
REQ-010 The block SHALL have port result, output, N bits: registered sum.
REQ-011 The block SHALL have port carry, output, 1 bit: registered carry-out.
REQ-012 The block SHALL have port zero, output, 1 bit: 1 when captured result == 0 and carry == 0.
REQ-013 The block SHALL have port done, output, 1 bit: result/carry/zero valid.
REQ-014 The block SHALL have port state, output, 2 bits: current FSM state encoding, for debug/LEDs.
REQ-015 The block SHALL have port op_count, output, 8 bits: number of completed additions.

Function
REQ-016 The block SHALL detect a load rising edge as load==1 with the previous-cycle registered load==0; a held load SHALL count as one edge only.
REQ-017 The FSM SHALL have states WAIT_A=2'b00, WAIT_B=2'b01, EXEC=2'b10, HOLD=2'b11, and state SHALL output this encoding.
REQ-018 In WAIT_A, a load edge SHALL capture din into a and move to WAIT_B; with no edge the state SHALL be held.
REQ-019 In WAIT_B, a load edge SHALL capture din into b and move to EXEC; with no edge the state SHALL be held.
REQ-020 EXEC SHALL last exactly one cycle: it SHALL capture sum_in into result and cout_in into carry, compute zero from the captured values, increment op_count, and move to HOLD.
REQ-021 Any load edge occurring in EXEC SHALL be ignored.
REQ-022 done SHALL be 1 only in HOLD; the latency from the B load edge to done==1 SHALL be 2 clk cycles.
REQ-023 In HOLD, result/carry/zero/a/b SHALL be stable; a load edge SHALL capture din into a, clear done, and move to WAIT_B (chained entry).
REQ-024 a and b SHALL change only on their capture edges and SHALL stay stable through EXEC, so the sum_in path settles within one cycle.
REQ-025 Arithmetic SHALL be unsigned modulo 2^N; carry SHALL be the (N+1)th bit; no saturation.
REQ-026 op_count SHALL wrap from 255 to 0 without a flag.
REQ-027 result, carry, and zero SHALL keep the previous operation's values in WAIT_A and WAIT_B until the next EXEC.

Reset
REQ-028 While rst==1, the block SHALL force state=WAIT_A, a=0, b=0, result=0, carry=0, zero=1, done=0, op_count=0, and the load-edge history register=1.
REQ-029 rst SHALL act immediately without a clock, including mid-operation in any state.
REQ-030 After rst deassertion, a load that is still held high SHALL NOT create an edge.

Verification
REQ-031 The bench SHALL apply N=4, load edge din=3, load edge din=5 -> after 2 cycles done=1, result=8, carry=0, zero=0, op_count=1.
REQ-032 The bench SHALL apply N=4, operands 9 then 7 -> result=0, carry=1, zero=0; then operands 0 and 0 -> result=0, carry=0, zero=1.
REQ-033 The bench SHALL hold load high for 10 cycles with din=2 in WAIT_A -> only a=2 is captured, state=WAIT_B, and b is unchanged.
REQ-034 From HOLD, the bench SHALL apply load edge din=15 then load edge din=1 -> done drops on the first edge, then result=0, carry=1, op_count incremented.
REQ-035 The bench SHALL assert rst asynchronously between clock edges during EXEC -> all outputs take their reset values immediately, state=WAIT_A, and the next entry starts at A.
REQ-036 The bench SHALL run 256 additions -> op_count wraps to 0, and done/result timing is unchanged.
